// File: rtl/riscv_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
module riscv_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [1:0]            Div_Op_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic                  Flush_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] MIN_INT  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic [W-1:0]     result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode and one restoring-division step
  logic             signed_op, rem_op, a_neg, b_neg, div_zero, overflow;
  logic [W-1:0]     a_abs, b_abs, special_val;
  logic [W+1:0]     trial;
  logic [W:0]       rem_nxt;
  logic [W-1:0]     quo_nxt, fin_quo, fin_rem;

  // Next-state, datapath and output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;

    signed_op = ~Div_Op_i[0];
    rem_op    = Div_Op_i[1];
    a_neg     = signed_op & A_i[W-1];
    b_neg     = signed_op & B_i[W-1];
    a_abs     = a_neg ? W'(-A_i) : A_i;
    b_abs     = b_neg ? W'(-B_i) : B_i;
    div_zero  = (B_i == '0);
    overflow  = signed_op && (A_i == MIN_INT) && (B_i == ALL_ONES);
    if (div_zero) begin
      special_val = rem_op ? A_i : ALL_ONES;
    end else begin
      special_val = rem_op ? '0 : MIN_INT;
    end

    // Shift in next dividend bit and trial-subtract the divisor
    trial = {rem_q, quo_q[W-1]} - {2'b00, dvs_q};
    if (trial[W+1]) begin
      rem_nxt = {rem_q[W-1:0], quo_q[W-1]};
      quo_nxt = {quo_q[W-2:0], 1'b0};
    end else begin
      rem_nxt = trial[W:0];
      quo_nxt = {quo_q[W-2:0], 1'b1};
    end
    fin_quo = neg_quo_q ? W'(-quo_nxt) : quo_nxt;
    fin_rem = neg_rem_q ? W'(-rem_nxt[W-1:0]) : rem_nxt[W-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start_i) begin
          if (div_zero || overflow) begin
            state_d  = S_DONE;
            result_d = special_val;
          end else begin
            state_d   = S_CALC;
            cnt_d     = CNT_W'(W - 1);
            rem_d     = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_rem_d  = rem_op;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = CNT_W'(cnt_q - 1'b1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = is_rem_q ? fin_rem : fin_quo;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts without touching the visible result
    if (Flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy_o   = busy_q;
  assign Done_o   = done_q;
  assign Result_o = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed and random bench for riscv_div_unit with a result scoreboard.
module tb_riscv_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result = '0;

  riscv_div_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start_i  (start_i),
    .Div_Op_i (op_i),
    .A_i      (a_i),
    .B_i      (b_i),
    .Flush_i  (flush_i),
    .Busy_o   (busy_o),
    .Done_o   (done_o),
    .Result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model following RISC-V M semantics
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Drive one request for a cycle; leaves the bench at the T+1 sample point
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    exp_q.push_back(model(op, a, b));
    lat = ((b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : W + 1;
    @(negedge clk);
  endtask

  // Follow an operation to completion; kind 1=ignored start, 2=flush, 3=reset at poke_cyc
  task automatic wait_done(input int lat, input int poke_cyc, input int kind);
    int           cyc = 1;
    bit           fin = 1'b0;
    logic [W-1:0] exp;
    while (!fin) begin
      start_i = 1'b0;
      flush_i = 1'b0;
      reset   = 1'b1;
      if (kind == 2 && cyc == poke_cyc + 1) begin
        chk("flush_busy", W'(busy_o), W'(0));
        chk("flush_done", W'(done_o), W'(0));
        chk("flush_result", result_o, last_result);
        void'(exp_q.pop_front());
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("flush_no_done", W'(done_o), W'(0));
        end
        chk("flush_result_held", result_o, last_result);
        return;
      end
      if (kind == 3 && cyc == poke_cyc + 1) begin
        chk("rst_busy", W'(busy_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        chk("rst_result", result_o, W'(0));
        void'(exp_q.pop_front());
        last_result = '0;
        return;
      end
      chk("busy", W'(busy_o), W'(cyc < lat));
      if (done_o) begin
        chk("done_latency", W'(cyc), W'(lat));
        exp = exp_q.pop_front();
        chk("result", result_o, exp);
        last_result = exp;
        fin = 1'b1;
      end else if (cyc > lat + 5) begin
        chk("done_timeout", W'(cyc), W'(lat));
        void'(exp_q.pop_front());
        fin = 1'b1;
      end
      if (!fin) begin
        if (cyc == poke_cyc) begin
          case (kind)
            1: begin
              start_i = 1'b1;
              op_i    = 2'd0;
              a_i     = 32'd50;
              b_i     = 32'd0;
            end
            2:       flush_i = 1'b1;
            3:       reset = 1'b0;
            default: ;
          endcase
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    int lat;
    reset   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy_o), W'(0));
    chk("reset_done", W'(done_o), W'(0));
    chk("reset_result", result_o, W'(0));
    reset = 1'b1;
    @(negedge clk);

    // DIVU 100/7 with full latency, then confirm pulse and hold
    issue(2'd1, 32'd100, 32'd7, lat);
    wait_done(lat, 0, 0);
    @(negedge clk);
    chk("done_pulse", W'(done_o), W'(0));
    chk("result_hold", result_o, 32'd14);

    // Signed quotient and remainder with negative dividend
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, lat);
    wait_done(lat, 0, 0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, lat);
    wait_done(lat, 0, 0);

    // Divide by zero, accepted back-to-back from DONE
    issue(2'd0, 32'd5, 32'd0, lat);
    wait_done(lat, 0, 0);
    issue(2'd3, 32'd5, 32'd0, lat);
    wait_done(lat, 0, 0);

    // Signed overflow
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    wait_done(lat, 0, 0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    wait_done(lat, 0, 0);

    // Flush mid-operation, then a fresh operation
    issue(2'd1, 32'd1000, 32'd3, lat);
    wait_done(lat, 10, 2);
    issue(2'd1, 32'd12345, 32'd67, lat);
    wait_done(lat, 0, 0);

    // Start ignored while busy
    issue(2'd1, 32'd1000, 32'd9, lat);
    wait_done(lat, 5, 1);

    // Reset in flight
    issue(2'd0, 32'hFFFF_0000, 32'd3, lat);
    wait_done(lat, 8, 3);

    // Back-to-back normal operations
    issue(2'd1, 32'd77, 32'd5, lat);
    wait_done(lat, 0, 0);
    issue(2'd3, 32'd77, 32'd5, lat);
    wait_done(lat, 0, 0);
    issue(2'd2, 32'h8000_0000, 32'd7, lat);
    wait_done(lat, 0, 0);

    // Random operations
    for (int i = 0; i < 10; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? W'($urandom_range(1, 40)) : $urandom;
      if (i % 2 == 1) rb = -rb;
      issue(rop, ra, rb, lat);
      wait_done(lat, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
